// File: rtl/serial_chunk_adder_if.sv
// Handshake and operand/result bundle for serial_chunk_adder.
// master drives the request side, slave is the adder itself.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: adds DIGIT bits per clock with a registered ripple carry,
// publishing sum/cout/ovf only on completion behind a start/busy/done handshake.
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  serial_chunk_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic             carry_reg;
  logic [KW-1:0]    k;

  logic [DIGIT:0]   chunk;
  logic [WIDTH-1:0] acc_next;
  logic             last;

  // Current chunk is added at full DIGIT+1 width so its carry is kept intact.
  always_comb begin
    chunk    = '0;
    acc_next = acc;
    last     = (k == KW'(N - 1));
    chunk    = {1'b0, a_reg[k*DIGIT +: DIGIT]}
             + {1'b0, b_reg[k*DIGIT +: DIGIT]}
             + {{DIGIT{1'b0}}, carry_reg};
    acc_next[k*DIGIT +: DIGIT] = chunk[DIGIT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      k         <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.sum   <= '0;
      bus.cout  <= 1'b0;
      bus.ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            acc       <= '0;
            k         <= '0;
            bus.busy  <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          acc       <= acc_next;
          carry_reg <= chunk[DIGIT];
          if (last) begin
            // Results are published from the combinational next value so the
            // final chunk lands in sum on the same edge that enters DONE.
            bus.sum  <= acc_next;
            bus.cout <= chunk[DIGIT];
            bus.ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
            bus.done <= 1'b1;
            k        <= '0;
            state    <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: a DIGIT=4 instance for timing,
// carry, overflow, isolation and reset, plus a DIGIT=16 instance for N=1.
module tb_serial_chunk_adder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [15:0] prev_sum;

  serial_chunk_adder_if #(.WIDTH(16)) if4 ();
  serial_chunk_adder_if #(.WIDTH(16)) if16 ();

  serial_chunk_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  serial_chunk_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the N=4 instance, checking timing and result hold.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] esum,
                        input logic ecout, input logic eovf);
    if4.a = a; if4.b = b; if4.cin = cin; if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    check({tag, "_busy_e0"}, {31'd0, if4.busy}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) check({tag, "_sumhold"}, {16'd0, if4.sum}, {16'd0, prev_sum});
      tick();
      if (i < 4) check({tag, "_nodone"}, {31'd0, if4.done}, 32'd0);
    end
    check({tag, "_done"}, {31'd0, if4.done}, 32'd1);
    check({tag, "_sum"},  {16'd0, if4.sum}, {16'd0, esum});
    check({tag, "_cout"}, {31'd0, if4.cout}, {31'd0, ecout});
    check({tag, "_ovf"},  {31'd0, if4.ovf}, {31'd0, eovf});
    tick();
    check({tag, "_done_e5"}, {31'd0, if4.done}, 32'd0);
    check({tag, "_busy_e5"}, {31'd0, if4.busy}, 32'd0);
    check({tag, "_sum_keep"}, {16'd0, if4.sum}, {16'd0, esum});
    prev_sum = esum;
  endtask

  initial begin
    checks = 0; errors = 0; prev_sum = 16'h0000;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
    rst_n = 1'b1;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, if4.busy}, 32'd0);
    check("rst_done", {31'd0, if4.done}, 32'd0);
    check("rst_sum",  {16'd0, if4.sum}, 32'h0);
    check("rst_cout", {31'd0, if4.cout}, 32'd0);
    check("rst_ovf",  {31'd0, if4.ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("carry1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("carry2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("ovfpos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovfneg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Restart and operand changes while busy must not disturb the result.
    if4.a = 16'h0F0F; if4.b = 16'h0101; if4.cin = 1'b0; if4.start = 1'b1;
    tick();
    if4.a = 16'hAAAA; if4.b = 16'h5555; if4.cin = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    tick();
    check("iso_nodone", {31'd0, if4.done}, 32'd0);
    tick();
    check("iso_done", {31'd0, if4.done}, 32'd1);
    check("iso_sum",  {16'd0, if4.sum}, 32'h1010);
    tick();
    check("iso_idle", {31'd0, if4.busy}, 32'd0);
    tick();
    check("iso_nodone2", {31'd0, if4.done}, 32'd0);
    check("iso_nobusy2", {31'd0, if4.busy}, 32'd0);
    prev_sum = 16'h1010;

    // Reset in the middle of a run aborts it and clears the outputs.
    if4.a = 16'h1234; if4.b = 16'h1111; if4.cin = 1'b0; if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, if4.busy}, 32'd0);
    check("midrst_sum",  {16'd0, if4.sum}, 32'h0);
    tick();
    tick();
    tick();
    check("midrst_nodone", {31'd0, if4.done}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_sum2", {16'd0, if4.sum}, 32'h0);
    prev_sum = 16'h0000;
    run_op("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Single-chunk configuration: done after the first edge following start.
    if16.a = 16'h1234; if16.b = 16'h4321; if16.cin = 1'b0; if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    check("n1_busy_e0", {31'd0, if16.busy}, 32'd1);
    check("n1_nodone_e0", {31'd0, if16.done}, 32'd0);
    tick();
    check("n1_done", {31'd0, if16.done}, 32'd1);
    check("n1_sum",  {16'd0, if16.sum}, 32'h5555);
    check("n1_cout", {31'd0, if16.cout}, 32'd0);
    tick();
    check("n1_done_e2", {31'd0, if16.done}, 32'd0);
    check("n1_busy_e2", {31'd0, if16.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
- Multi-cycle parametrised adder. It adds two WIDTH-bit operands plus a carry-in, processing DIGIT bits per clock and holding the ripple carry in a register between chunks.
- It is the sequential successor to the single-bit full adder. It trades latency for area in wide datapaths, and uses a start/busy/done handshake so it can sit behind a controller FSM.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥1.
- DIGIT, 4, bits added per cycle; WIDTH must be an integer multiple of DIGIT.
- N (localparam), WIDTH/DIGIT, number of compute cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- cin  input  1  carry-in; latched on an accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; the result is valid from this cycle on.
- sum  output  WIDTH  registered result.
- cout  output  1  unsigned carry-out.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous, regardless of state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal operand, accumulator, carry and chunk-index registers all cleared.
  - Reset deassertion takes effect at the next clk edge; no partial result is ever published.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a, b, cin into internal registers; carry_reg=cin; k=0; go to RUN.
  - On an edge with start=0: stay in IDLE; outputs hold.
- RUN, at each edge:
  - {c, s} = a_reg[k*DIGIT +: DIGIT] + b_reg[k*DIGIT +: DIGIT] + carry_reg. This is a (DIGIT+1)-bit add; no truncation before the carry is taken.
  - Write s into acc[k*DIGIT +: DIGIT]; carry_reg=c; k=k+1.
  - When k==N-1 at the edge, the final chunk is processed at that edge and the FSM goes to DONE.
- Transfer into DONE, at the same edge:
  - sum=final accumulator value; cout=final carry.
  - ovf=(a_reg[MSB]==b_reg[MSB]) && (sum[MSB]!=a_reg[MSB]).
  - done=1.
- DONE: lasts exactly one cycle. Next edge: done=0, go to IDLE. start is ignored in DONE.
- Latency:
  - start is sampled at edge E0; done is high in the cycle after edge EN.
  - A new start is accepted at edge EN+2 at the earliest.
  - Throughput: one result per N+2 cycles.
- Output hold:
  - sum, cout and ovf change only on the transfer into DONE.
  - During RUN they hold the previous result.
  - They persist in IDLE until the next completion.
- start while busy=1: ignored. No queuing, no error flag.
- Operand isolation: changes on a, b, cin after acceptance have no effect on the result in progress.
- DIGIT==WIDTH (N=1): RUN lasts one edge, giving the same single-cycle-add timing with done at E1.
- Wrap-around: the result is modulo 2^WIDTH; the carry out of the top chunk goes to cout only.
- Reset mid-RUN: the operation is aborted, done never pulses, and sum/cout/ovf clear to 0.

Test Plan:
Bench configuration is WIDTH=16, DIGIT=4 (N=4) unless noted.
1. Reset: rst_n=0 asynchronously, mid-cycle, with no clock edge → busy=0, done=0, sum=0x0000, cout=0, ovf=0 immediately.
2. Basic add: a=0x1234, b=0x4321, cin=0, start pulse at E0 → busy high from E0, done high only after E4 (one cycle), sum=0x5555, cout=0, ovf=0. Then idle at E5.
3. Carry chain:
   - 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0.
   - 0xFFFF+0x0000, cin=1 → sum=0x0000, cout=1.
   - Both cases check ripple across all 4 chunks.
4. Signed overflow:
   - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
   - 0x8000+0x8000 → sum=0x0000, cout=1, ovf=1.
5. Handshake isolation: start 0x0F0F+0x0101, then in RUN re-pulse start with a=0xAAAA and change b → single done, sum=0x1010. The second start produces no effect and no extra done.
6. Reset mid-run plus N=1:
   - Start 0x1234+0x1111; assert rst_n=0 after E2 → no done, sum=0.
   - After release, start 0x0001+0x0002 → sum=0x0003.
   - Repeat test 2 with DIGIT=16 → done after E1.
